// File: rtl/pr_timer.sv
// rtl/pr_timer.sv - memory-mapped countdown timer with one-shot/auto-reload modes and masked IRQ
module pr_timer #(
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Sel,
    input  logic [1:0]    Addr,
    input  logic          We,
    input  logic [DW-1:0] DIn,
    output logic [DW-1:0] DOut,
    output logic          IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q, count_d;
    logic          irq_flag_q, irq_flag_d;

    logic wr_en;
    logic enable;
    logic auto_reload;
    logic unused_din_hi;

    assign wr_en       = We & Sel;
    assign enable      = ctrl_q[0];
    // Mode encodings 2 and 3 fall back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    // CTRL only keeps bits [3:0]; the upper write-data bits are dropped.
    assign unused_din_hi = ^DIn[DW-1:4];

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_q > ONE) begin
                    count_d = count_q - ONE;
                end else begin
                    // A zero PRESET expires on the first count cycle, never wraps.
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes are applied last so they override the FSM's CTRL and flag updates.
        if (wr_en) begin
            if (Addr == 2'd0) begin
                ctrl_d     = DIn[3:0];
                irq_flag_d = 1'b0;
            end else if (Addr == 2'd1) begin
                preset_d = DIn;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        DOut = '0;
        unique case (Addr)
            2'd0:    DOut = {{(DW-4){1'b0}}, ctrl_q};
            2'd1:    DOut = preset_q;
            2'd2:    DOut = count_q;
            default: DOut = '0;
        endcase
    end

    assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_pr_timer.sv
// tb/tb_pr_timer.sv - randomized and directed checking of pr_timer against a behavioural model
module tb_pr_timer;

    logic        Clk;
    logic        Reset;
    logic        Sel;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    int n_checks = 0;
    int n_errors = 0;

    pr_timer #(.DW(32)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Sel   (Sel),
        .Addr  (Addr),
        .We    (We),
        .DIn   (DIn),
        .DOut  (DOut),
        .IRQ   (IRQ)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: register values plus where the timer is in its countdown.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    logic        m_load_next;   // reload COUNT from PRESET at the coming edge
    logic        m_running;     // countdown in progress
    logic        m_expired;     // countdown reached zero at the previous edge

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input int a);
        case (a)
            0:       return {28'd0, m_ctrl};
            1:       return m_preset;
            2:       return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic wr, input logic [1:0] addr,
                              input logic [31:0] din);
        logic en;
        logic auto_mode;
        if (rst) begin
            m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
            m_load_next = 1'b0; m_running = 1'b0; m_expired = 1'b0;
            return;
        end
        en        = m_ctrl[0];
        auto_mode = (m_ctrl[2:1] == 2'b01);
        if (m_expired) begin
            m_expired = 1'b0;
            if (auto_mode) begin
                m_flag      = 1'b0;
                m_load_next = 1'b1;
            end else begin
                m_ctrl[0] = 1'b0;
            end
        end else if (m_load_next) begin
            m_count     = m_preset;
            m_load_next = 1'b0;
            m_running   = 1'b1;
        end else if (m_running) begin
            if (!en) begin
                m_running = 1'b0;
            end else if (m_count > 1) begin
                m_count = m_count - 1;
            end else begin
                m_count   = 32'd0;
                m_flag    = 1'b1;
                m_running = 1'b0;
                m_expired = 1'b1;
            end
        end else if (en) begin
            m_load_next = 1'b1;
        end
        if (wr && addr == 2'd0) begin
            m_ctrl = din[3:0];
            m_flag = 1'b0;
        end
        if (wr && addr == 2'd1) m_preset = din;
    endtask

    // One clock: drive inputs, advance model at the edge, then check IRQ and all four reads.
    task automatic cyc(input logic rst, input logic sel, input logic we,
                       input logic [1:0] addr, input logic [31:0] din);
        Reset = rst; Sel = sel; We = we; Addr = addr; DIn = din;
        @(posedge Clk);
        model_step(rst, sel & we, addr, din);
        #1;
        Reset = 1'b0; Sel = 1'b0; We = 1'b0;
        chk("irq", {31'd0, IRQ}, {31'd0, m_ctrl[3] & m_flag});
        for (int a = 0; a < 4; a++) begin
            Addr = a[1:0];
            #1;
            chk($sformatf("rd%0d", a), DOut, model_rd(a));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] din);
        cyc(1'b0, 1'b1, 1'b1, addr, din);
    endtask

    int pulses;

    initial begin
        Reset = 1'b1; Sel = 1'b0; We = 1'b0; Addr = 2'd0; DIn = 32'd0;
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
        m_load_next = 1'b0; m_running = 1'b0; m_expired = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("reset_irq", {31'd0, IRQ}, 32'd0);

        // One-shot, PRESET=3: IRQ first seen after E+5.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int i = 1; i <= 6; i++) begin
            idle(1);
            if (i == 4) chk("m0_irq_e4", {31'd0, IRQ}, 32'd0);
            if (i == 5) chk("m0_irq_e5", {31'd0, IRQ}, 32'd1);
        end
        Addr = 2'd0; #1;
        chk("m0_ctrl_e6", DOut, 32'h8);
        idle(3);
        chk("m0_irq_hold", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h8);
        chk("m0_irq_clr", {31'd0, IRQ}, 32'd0);

        // Auto-reload, PRESET=2: one pulse every 4 cycles.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            idle(1);
            if (IRQ) pulses++;
        end
        chk("m1_pulses", pulses, 32'd5);
        wr(2'd0, 32'h0);
        idle(3);

        // PRESET=0 one-shot: IRQ at E+3.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        idle(2);
        chk("p0_irq_e2", {31'd0, IRQ}, 32'd0);
        idle(1);
        chk("p0_irq_e3", {31'd0, IRQ}, 32'd1);
        wr(2'd0, 32'h0);

        // IM=0: no IRQ, but Enable self-clears and COUNT ends at 0.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        idle(8);
        chk("im0_irq", {31'd0, IRQ}, 32'd0);

        // Pause mid-count, then re-enable and reload.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        idle(7);
        wr(2'd0, 32'h8);
        idle(4);
        wr(2'd0, 32'h9);
        idle(4);

        // PRESET change while counting in auto-reload.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'hB);
        idle(3);
        wr(2'd1, 32'd7);
        idle(20);
        wr(2'd0, 32'h0);

        // Write gating and mid-count reset.
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 32'h1234);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 32'hF);
        wr(2'd2, 32'h55);
        wr(2'd3, 32'h66);
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        idle(6);
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("rst_irq", {31'd0, IRQ}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst;
            logic        r_sel;
            logic        r_we;
            logic [1:0]  r_addr;
            logic [31:0] r_din;
            r_rst  = ($urandom_range(0, 79) == 0);
            r_sel  = ($urandom_range(0, 3) != 0);
            r_we   = ($urandom_range(0, 5) == 0);
            r_addr = 2'($urandom_range(0, 3));
            r_din  = $urandom;
            if (r_addr == 2'd1) r_din = $urandom_range(0, 6);
            if (r_addr == 2'd0 && $urandom_range(0, 3) != 0) r_din[0] = 1'b1;
            cyc(r_rst, r_sel, r_we, r_addr, r_din);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
